// File: rtl/exec_pkg.sv
// Shared opcode/state encodings for the execute/writeback stage.
package exec_pkg;

  localparam int unsigned REG_IDX_W = 2;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpNot = 3'b100,
    OpMov = 3'b101,
    OpMul = 3'b110,
    OpNop = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StMul  = 2'b10,
    StWb   = 2'b11
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per step, sequenced by the caller.
module seq_multiplier #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned MUL_CYCLES  = WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic [WORD_LENGTH-1:0]   i_multiplicand,
  input  logic [WORD_LENGTH-1:0]   i_multiplier,
  output logic [2*WORD_LENGTH-1:0] o_product,
  output logic                     o_last
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [2*WORD_LENGTH-1:0] r_mcand;
  logic [2*WORD_LENGTH-1:0] r_product;
  logic [WORD_LENGTH-1:0]   r_mplier;
  logic [CntW-1:0]          r_cnt;
  logic [2*WORD_LENGTH-1:0] w_product_next;

  assign w_product_next = r_mplier[0] ? (r_product + r_mcand) : r_product;

  // Exposes the product including the step in flight, so the caller can
  // capture the final value on the same edge that completes the last step.
  assign o_product = w_product_next;
  assign o_last    = (r_cnt == CntW'(MUL_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_product <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
    end else if (i_load) begin
      r_mcand   <= {{WORD_LENGTH{1'b0}}, i_multiplicand};
      r_product <= '0;
      r_mplier  <= i_multiplier;
      r_cnt     <= '0;
    end else if (i_step) begin
      r_product <= w_product_next;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_cnt     <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute/writeback stage feeding the accumulator register file write port.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned MUL_CYCLES  = WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [REG_IDX_W-1:0]   dst_reg,
  input  logic [WORD_LENGTH-1:0] operand_a,
  input  logic [WORD_LENGTH-1:0] operand_b,
  output logic                   busy,
  output logic                   done,
  output logic [REG_IDX_W-1:0]   write_reg,
  output logic [WORD_LENGTH-1:0] write_data,
  output logic                   write_reg_en,
  output logic                   zero_flag,
  output logic                   carry_flag
);

  state_e                   r_state;
  op_e                      r_op;
  logic [REG_IDX_W-1:0]     r_dst;
  logic [WORD_LENGTH-1:0]   r_a;
  logic [WORD_LENGTH-1:0]   r_b;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_wr_en;
  logic [REG_IDX_W-1:0]     r_wr_reg;
  logic [WORD_LENGTH-1:0]   r_wr_data;
  logic                     r_zero;
  logic                     r_carry;

  logic [WORD_LENGTH:0]     w_sum;
  logic [WORD_LENGTH-1:0]   w_result;
  logic                     w_carry;
  logic                     w_wb_go;
  logic                     w_mul_load;
  logic                     w_mul_step;
  logic                     w_mul_last;
  logic [2*WORD_LENGTH-1:0] w_product;
  op_e                      w_op_in;

  assign w_op_in    = op_e'(op);
  assign w_mul_load = (r_state == StIdle) && start && (w_op_in == OpMul);
  assign w_mul_step = (r_state == StMul);

  seq_multiplier #(
    .WORD_LENGTH (WORD_LENGTH),
    .MUL_CYCLES  (MUL_CYCLES)
  ) u_mul (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_mul_load),
    .i_step         (w_mul_step),
    .i_multiplicand (operand_a),
    .i_multiplier   (operand_b),
    .o_product      (w_product),
    .o_last         (w_mul_last)
  );

  // Bit WORD_LENGTH carries the ADD carry-out or the SUB borrow.
  always_comb begin
    w_sum = '0;
    unique case (r_op)
      OpAdd:   w_sum = {1'b0, r_a} + {1'b0, r_b};
      OpSub:   w_sum = {1'b0, r_a} - {1'b0, r_b};
      OpAnd:   w_sum = {1'b0, r_a & r_b};
      OpOr:    w_sum = {1'b0, r_a | r_b};
      OpNot:   w_sum = {1'b0, ~r_a};
      OpMov:   w_sum = {1'b0, r_b};
      default: w_sum = '0;
    endcase
  end

  assign w_result = (r_state == StMul) ? w_product[WORD_LENGTH-1:0] : w_sum[WORD_LENGTH-1:0];
  assign w_carry  = (r_state == StMul) ? (|w_product[2*WORD_LENGTH-1:WORD_LENGTH])
                                       : w_sum[WORD_LENGTH];
  assign w_wb_go  = (r_state == StExec) || ((r_state == StMul) && w_mul_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_op      <= OpNop;
      r_dst     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op    <= w_op_in;
            r_dst   <= dst_reg;
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_busy  <= 1'b1;
            r_state <= (w_op_in == OpMul) ? StMul : StExec;
          end
        end
        StExec, StMul: begin
          if (w_wb_go) begin
            r_state  <= StWb;
            r_done   <= 1'b1;
            r_wr_reg <= r_dst;
            // NOP still pulses done but leaves the data and flags untouched.
            if (r_op != OpNop) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_result;
              r_zero    <= (w_result == '0);
              r_carry   <= w_carry;
            end
          end
        end
        StWb: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign write_reg    = r_wr_reg;
  assign write_data   = r_wr_data;
  assign write_reg_en = r_wr_en;
  assign zero_flag    = r_zero;
  assign carry_flag   = r_carry;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: random and directed ops against an arithmetic reference model.
module tb_exec_unit;

  localparam int WL  = 8;
  localparam int MOD = 1 << WL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [1:0]    dst_reg = 2'd0;
  logic [WL-1:0] operand_a = '0;
  logic [WL-1:0] operand_b = '0;
  logic          busy;
  logic          done;
  logic [1:0]    write_reg;
  logic [WL-1:0] write_data;
  logic          write_reg_en;
  logic          zero_flag;
  logic          carry_flag;

  always #5 clk = ~clk;

  exec_unit #(
    .WORD_LENGTH (WL),
    .MUL_CYCLES  (WL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .dst_reg      (dst_reg),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_reg_en (write_reg_en),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag)
  );

  typedef struct {
    int unsigned   wb_cyc;
    logic [1:0]    dst;
    logic          en;
    logic [WL-1:0] data;
    logic          z;
    logic          c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic        mz = 1'b0;
  logic        mc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's meaning.
  task automatic model(input logic [2:0] o, input logic [1:0] d, input logic [WL-1:0] a,
                       input logic [WL-1:0] b, input int unsigned s, output exp_t e);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r = 0;
    logic c = 1'b0;
    case (o)
      3'd0: begin r = ua + ub; c = (r >= MOD); end
      3'd1: begin r = ua + MOD - ub; c = (ua < ub); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ (MOD - 1);
      3'd5: r = ub;
      3'd6: begin r = ua * ub; c = (r >= MOD); end
      default: r = 0;
    endcase
    e.dst    = d;
    e.en     = (o != 3'd7);
    e.data   = WL'(r % MOD);
    e.wb_cyc = s + ((o == 3'd6) ? (WL + 1) : 2);
    if (e.en) begin
      mz = ((r % MOD) == 0);
      mc = c;
    end
    e.z = mz;
    e.c = mc;
  endtask

  // Waits for idle, issues one op, optionally holds start (ignored while busy).
  task automatic issue(input logic [2:0] o, input logic [1:0] d, input logic [WL-1:0] a,
                       input logic [WL-1:0] b, input bit push, input int hold);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", 1, 0);
    start     = 1'b1;
    op        = o;
    dst_reg   = d;
    operand_a = a;
    operand_b = b;
    if (push) begin
      model(o, d, a, b, cyc, e);
      sb.push_back(e);
    end
    @(negedge clk);
    op        = 3'($urandom);
    dst_reg   = 2'($urandom);
    operand_a = WL'($urandom);
    operand_b = WL'($urandom);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : monitor
    logic [WL-1:0] ld;
    logic [1:0]    lr;
    logic          lz;
    logic          lc;
    exp_t          e;
    ld = '0; lr = '0; lz = 1'b0; lc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ld = '0; lr = '0; lz = 1'b0; lc = 1'b0;
        continue;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc, e.wb_cyc);
          check("write_en", write_reg_en, e.en);
          lr = e.dst;
          if (e.en) begin
            ld = e.data;
            lz = e.z;
            lc = e.c;
          end
        end
      end else begin
        check("we_outside_wb", write_reg_en, 0);
      end
      check("write_reg", write_reg, lr);
      check("write_data", write_data, ld);
      check("zero_flag", zero_flag, lz);
      check("carry_flag", carry_flag, lc);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", write_reg_en, 0);
    check("rst_data", write_data, 0);
    check("rst_reg", write_reg, 0);
    check("rst_flags", {zero_flag, carry_flag}, 0);
    rst = 1'b0;

    issue(3'd0, 2'd2, 8'hF0, 8'h20, 1, 0);
    issue(3'd7, 2'd0, 8'h00, 8'h00, 1, 0);
    issue(3'd1, 2'd1, 8'h05, 8'h05, 1, 0);
    issue(3'd1, 2'd1, 8'h03, 8'h07, 1, 1);

    // MUL: busy for exactly 9 cycles after the start edge.
    issue(3'd6, 2'd3, 8'h0C, 8'h0B, 1, 0);
    for (int i = 0; i < WL + 1; i++) begin
      check("mul_busy", busy, 1);
      @(negedge clk);
    end
    check("mul_idle", busy, 0);

    // Start with ADD while the multiplier runs must be ignored.
    issue(3'd6, 2'd0, 8'h10, 8'h10, 1, 0);
    start = 1'b1;
    op = 3'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;

    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom), WL'($urandom), WL'($urandom), 1,
            $urandom_range(0, 2));
    end

    // Abort a MUL with reset mid-flight; nothing may be written.
    issue(3'd6, 2'd2, 8'hFF, 8'hFF, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", write_reg_en, 0);
    check("abort_done", done, 0);
    check("abort_data", write_data, 0);
    mz = 1'b0;
    mc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 2'd1, 8'h01, 8'h01, 1, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
